// File: rtl/bpred_pkg.sv
// ----------------------------------------------------------------------------
// bpred_pkg -- shared constants for the two-bit branch predictor table
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package bpred_pkg;

  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;

  localparam logic [1:0] CTR_RESET = WNT;

  localparam int STATS_W = 32;

endpackage

`default_nettype wire

// File: rtl/sat_counter2.sv
// ----------------------------------------------------------------------------
// sat_counter2 -- next-state function of a 2-bit saturating counter
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sat_counter2
  import bpred_pkg::*;
(
  input  logic [1:0] cnt_i,
  input  logic       taken_i,
  output logic [1:0] cnt_o
);

  always_comb begin
    cnt_o = cnt_i;
    if (taken_i) begin
      if (cnt_i != ST) cnt_o = cnt_i + 2'd1;
    end else begin
      if (cnt_i != SNT) cnt_o = cnt_i - 2'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/branch_predictor_table.sv
// ----------------------------------------------------------------------------
// branch_predictor_table -- untagged 2-bit saturating-counter predictor
// Optional statistics counters: define BPRED_STATS_EN.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module branch_predictor_table
  import bpred_pkg::*;
#(
  parameter int ADDRESS_SIZE = 6,
  parameter int INDEX_BITS   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         if_stall,
  input  logic                         if_flush,
  input  logic [(2**ADDRESS_SIZE)-1:0] lookup_ptr,
  input  logic                         lookup_is_beq,
  input  logic                         upd_valid,
  input  logic [(2**ADDRESS_SIZE)-1:0] upd_ptr,
  input  logic                         upd_taken,
  input  logic                         upd_predicted,
  output logic                         predictor_val,
  output logic                         mispredict
`ifdef BPRED_STATS_EN
  ,
  output logic [STATS_W-1:0]           branch_cnt,
  output logic [STATS_W-1:0]           mispredict_cnt
`endif
);

  localparam int PTR_W   = 2**ADDRESS_SIZE;
  localparam int ENTRIES = 2**INDEX_BITS;

  logic [1:0]            table_q [ENTRIES];
  logic [INDEX_BITS-1:0] lookup_idx;
  logic [INDEX_BITS-1:0] upd_idx;
  logic [1:0]            upd_next;
  logic [1:0]            lookup_cnt;
  logic                  raw_pred;
  logic                  pred_d, pred_q;
  logic                  mispredict_d, mispredict_q;
  logic                  unused_ptr_bits;

  // Word-aligned index; the remaining pointer bits are deliberately ignored (no tag).
  assign lookup_idx = lookup_ptr[INDEX_BITS+1:2];
  assign upd_idx    = upd_ptr[INDEX_BITS+1:2];
  assign unused_ptr_bits = ^{lookup_ptr[PTR_W-1:INDEX_BITS+2], lookup_ptr[1:0],
                             upd_ptr[PTR_W-1:INDEX_BITS+2], upd_ptr[1:0]};

  sat_counter2 u_upd_ctr (
    .cnt_i   (table_q[upd_idx]),
    .taken_i (upd_taken),
    .cnt_o   (upd_next)
  );

  // Same-cycle update to the looked-up entry is forwarded so the lookup sees the new state.
  assign lookup_cnt   = (upd_valid && (upd_idx == lookup_idx)) ? upd_next : table_q[lookup_idx];
  assign raw_pred     = lookup_cnt[1] & lookup_is_beq;
  assign mispredict_d = upd_valid & (upd_taken ^ upd_predicted);

  always_comb begin
    pred_d = pred_q;
    if (if_flush)       pred_d = 1'b0;
    else if (!if_stall) pred_d = raw_pred;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int e = 0; e < ENTRIES; e++) table_q[e] <= CTR_RESET;
    end else if (upd_valid) begin
      table_q[upd_idx] <= upd_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pred_q       <= 1'b0;
      mispredict_q <= 1'b0;
    end else begin
      pred_q       <= pred_d;
      mispredict_q <= mispredict_d;
    end
  end

  assign predictor_val = pred_q;
  assign mispredict    = mispredict_q;

`ifdef BPRED_STATS_EN
  logic [STATS_W-1:0] branch_cnt_q;
  logic [STATS_W-1:0] mispredict_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      if (upd_valid)    branch_cnt_q     <= branch_cnt_q + 1'b1;
      if (mispredict_d) mispredict_cnt_q <= mispredict_cnt_q + 1'b1;
    end
  end

  assign branch_cnt     = branch_cnt_q;
  assign mispredict_cnt = mispredict_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor_table.sv
// ----------------------------------------------------------------------------
// tb_branch_predictor_table -- directed self-checking bench for branch_predictor_table
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_branch_predictor_table;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_stall = 1'b0;
  logic        if_flush = 1'b0;
  logic [63:0] lookup_ptr = '0;
  logic        lookup_is_beq = 1'b0;
  logic        upd_valid = 1'b0;
  logic [63:0] upd_ptr = '0;
  logic        upd_taken = 1'b0;
  logic        upd_predicted = 1'b0;
  logic        predictor_val;
  logic        mispredict;
`ifdef BPRED_STATS_EN
  logic [31:0] branch_cnt;
  logic [31:0] mispredict_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int exp_branches = 0;
  int exp_mispredicts = 0;

  always #5 clk = ~clk;

  branch_predictor_table #(.ADDRESS_SIZE(6), .INDEX_BITS(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .if_stall      (if_stall),
    .if_flush      (if_flush),
    .lookup_ptr    (lookup_ptr),
    .lookup_is_beq (lookup_is_beq),
    .upd_valid     (upd_valid),
    .upd_ptr       (upd_ptr),
    .upd_taken     (upd_taken),
    .upd_predicted (upd_predicted),
    .predictor_val (predictor_val),
    .mispredict    (mispredict)
`ifdef BPRED_STATS_EN
    ,
    .branch_cnt    (branch_cnt),
    .mispredict_cnt(mispredict_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, clock it, and return 1 time unit after the edge.
  task automatic cyc(input logic [63:0] lptr, input logic lbeq, input logic uv,
                     input logic [63:0] uptr, input logic ut, input logic up);
    lookup_ptr    = lptr;
    lookup_is_beq = lbeq;
    upd_valid     = uv;
    upd_ptr       = uptr;
    upd_taken     = ut;
    upd_predicted = up;
    @(posedge clk);
    #1;
    if (uv && rst) begin
      exp_branches++;
      if (ut != up) exp_mispredicts++;
    end
  endtask

  task automatic idle();
    cyc(64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_pred", {31'd0, predictor_val}, 32'd0);
    check("reset_misp", {31'd0, mispredict}, 32'd0);
`ifdef BPRED_STATS_EN
    check("reset_bcnt", branch_cnt, 32'd0);
    check("reset_mcnt", mispredict_cnt, 32'd0);
`endif
    rst = 1'b1;

    // Fresh entry is WNT -> not taken
    cyc(64'h40, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
    check("wnt_lookup", {31'd0, predictor_val}, 32'd0);

    // Mispredict pulse on index 5 (ptr 0x14)
    cyc(64'h0, 1'b0, 1'b1, 64'h14, 1'b1, 1'b0);
    check("misp_pulse", {31'd0, mispredict}, 32'd1);
`ifdef BPRED_STATS_EN
    check("bcnt_one", branch_cnt, 32'd1);
    check("mcnt_one", mispredict_cnt, 32'd1);
`endif
    idle();
    check("misp_clear", {31'd0, mispredict}, 32'd0);

    // Train 0x40 (idx 0): 1 -> 2 -> 3
    cyc(64'h0, 1'b0, 1'b1, 64'h40, 1'b1, 1'b1);
    cyc(64'h0, 1'b0, 1'b1, 64'h40, 1'b1, 1'b1);
    check("no_misp", {31'd0, mispredict}, 32'd0);
    cyc(64'h40, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
    check("st_lookup", {31'd0, predictor_val}, 32'd1);
    cyc(64'h40, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
    check("non_branch", {31'd0, predictor_val}, 32'd0);
    cyc(64'h44, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
    check("other_idx", {31'd0, predictor_val}, 32'd0);
    // Saturation at ST, then decrement with bypassed lookup: 3,2,1,0,0
    cyc(64'h40, 1'b1, 1'b1, 64'h40, 1'b1, 1'b1);
    check("sat_st", {31'd0, predictor_val}, 32'd1);
    cyc(64'h40, 1'b1, 1'b1, 64'h40, 1'b0, 1'b0);
    check("dec_to_2", {31'd0, predictor_val}, 32'd1);
    cyc(64'h40, 1'b1, 1'b1, 64'h40, 1'b0, 1'b0);
    check("dec_to_1", {31'd0, predictor_val}, 32'd0);
    cyc(64'h40, 1'b1, 1'b1, 64'h40, 1'b0, 1'b0);
    check("dec_to_0", {31'd0, predictor_val}, 32'd0);
    cyc(64'h40, 1'b1, 1'b1, 64'h40, 1'b0, 1'b0);
    check("sat_snt", {31'd0, predictor_val}, 32'd0);
    // One taken step from SNT must still predict not-taken
    cyc(64'h0, 1'b0, 1'b1, 64'h40, 1'b1, 1'b1);
    cyc(64'h40, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
    check("snt_plus1", {31'd0, predictor_val}, 32'd0);

    // Bypass: entry WNT, taken update and lookup in the same cycle
    cyc(64'h40, 1'b1, 1'b1, 64'h40, 1'b1, 1'b0);
    check("bypass", {31'd0, predictor_val}, 32'd1);
    check("bypass_misp", {31'd0, mispredict}, 32'd1);

    // Stall holds, stall+flush clears
    if_stall = 1'b1;
    cyc(64'h44, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
    check("stall_hold1", {31'd0, predictor_val}, 32'd1);
    cyc(64'h48, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
    check("stall_hold2", {31'd0, predictor_val}, 32'd1);
    if_flush = 1'b1;
    cyc(64'h40, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
    check("stall_flush", {31'd0, predictor_val}, 32'd0);
    if_stall = 1'b0;
    if_flush = 1'b0;

`ifdef BPRED_STATS_EN
    check("bcnt_total", branch_cnt, exp_branches);
    check("mcnt_total", mispredict_cnt, exp_mispredicts);
`endif

    // Mid-stream asynchronous reset
    cyc(64'h40, 1'b1, 1'b1, 64'h14, 1'b0, 1'b1);
    check("pre_rst_pred", {31'd0, predictor_val}, 32'd1);
    check("pre_rst_misp", {31'd0, mispredict}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_pred", {31'd0, predictor_val}, 32'd0);
    check("async_rst_misp", {31'd0, mispredict}, 32'd0);
`ifdef BPRED_STATS_EN
    check("async_rst_bcnt", branch_cnt, 32'd0);
`endif
    #2;
    rst = 1'b1;
    // Table back to WNT everywhere: idx 0 was 2 before reset
    cyc(64'h40, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
    check("post_rst_lookup", {31'd0, predictor_val}, 32'd0);
    cyc(64'h40, 1'b1, 1'b1, 64'h40, 1'b1, 1'b1);
    check("post_rst_bypass", {31'd0, predictor_val}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
